// File: rtl/video_pattern_gen.sv
// Test-pattern generator for a DVI path: passes upstream timing through a fixed two-stage
// pipeline and paints colour bars, a per-frame solid colour, a grid or a gray ramp.
module video_pattern_gen #(
    parameter int unsigned H_RES      = 1280,
    parameter int unsigned V_RES      = 720,
    parameter int unsigned GRID_LOG2  = 5,
    parameter int unsigned GRAD_SHIFT = 2
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst,
    input  logic       I_en,
    input  logic [1:0] I_mode,
    input  logic       I_de,
    input  logic       I_hs,
    input  logic       I_vs,
    output logic       O_de,
    output logic       O_hs,
    output logic       O_vs,
    output logic [7:0] O_r,
    output logic [7:0] O_g,
    output logic [7:0] O_b,
    output logic       O_frame_done
);

    localparam int unsigned BarW   = (H_RES / 8 > 0) ? H_RES / 8 : 1;
    localparam logic [11:0] BarW12 = 12'(BarW);
    localparam logic [11:0] CntMax = 12'hFFF;

    if (H_RES < 8 || V_RES == 0 || GRID_LOG2 == 0 || GRID_LOG2 > 12) begin : g_param_check
        $error("video_pattern_gen: unsupported parameter combination");
    end

    // Input edge detection
    logic de_prev_q, vs_prev_q, armed_q;
    logic de_fall, vs_rise;

    // armed_q blocks a false vs edge when reset releases with I_vs already high
    assign de_fall = de_prev_q & ~I_de;
    assign vs_rise = armed_q & I_vs & ~vs_prev_q;

    // Position, mode and frame state
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [2:0]  frame_q, frame_d;
    logic [1:0]  mode_q, mode_d;

    always_comb begin
        x_d = x_q;
        if (de_fall) begin
            x_d = '0;
        end else if (I_de && x_q != CntMax) begin
            x_d = x_q + 12'd1;
        end

        y_d = y_q;
        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall && y_q != CntMax) begin
            y_d = y_q + 12'd1;
        end

        mode_d  = vs_rise ? I_mode : mode_q;
        frame_d = vs_rise ? frame_q + 3'd1 : frame_q;
    end

    // Stage-1 colour select
    logic [11:0] bar_div;
    logic [2:0]  bar_idx;
    logic        grid_hit;
    logic [2:0]  idx_d;
    logic        gray_d;
    logic [7:0]  level_d;

    assign bar_div  = x_q / BarW12;
    assign bar_idx  = (bar_div > 12'd7) ? 3'd7 : bar_div[2:0];
    assign grid_hit = (x_q[GRID_LOG2-1:0] == '0) || (y_q[GRID_LOG2-1:0] == '0);

    always_comb begin
        idx_d   = 3'd7;
        gray_d  = 1'b0;
        level_d = 8'(x_q >> GRAD_SHIFT);
        unique case (mode_q)
            2'd0: idx_d = bar_idx;
            2'd1: idx_d = frame_q;
            2'd2: idx_d = grid_hit ? 3'd0 : 3'd7;
            2'd3: gray_d = 1'b1;
            default: idx_d = 3'd7;
        endcase
    end

    logic       de_s1_q, hs_s1_q, vs_s1_q, en_s1_q, rise_s1_q;
    logic       gray_s1_q;
    logic [2:0] idx_s1_q;
    logic [7:0] level_s1_q;

    // Stage-2 palette lookup and blanking
    logic [2:0] mask;
    logic [7:0] r_d, g_d, b_d;

    always_comb begin
        mask = 3'b000;
        unique case (idx_s1_q)
            3'd0: mask = 3'b111;
            3'd1: mask = 3'b110;
            3'd2: mask = 3'b011;
            3'd3: mask = 3'b010;
            3'd4: mask = 3'b101;
            3'd5: mask = 3'b100;
            3'd6: mask = 3'b001;
            3'd7: mask = 3'b000;
            default: mask = 3'b000;
        endcase

        r_d = gray_s1_q ? level_s1_q : {8{mask[2]}};
        g_d = gray_s1_q ? level_s1_q : {8{mask[1]}};
        b_d = gray_s1_q ? level_s1_q : {8{mask[0]}};
        if (!(de_s1_q && en_s1_q)) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    logic       de_s2_q, hs_s2_q, vs_s2_q, fd_s2_q;
    logic [7:0] r_s2_q, g_s2_q, b_s2_q;

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            mode_q     <= '0;
            de_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            en_s1_q    <= 1'b0;
            rise_s1_q  <= 1'b0;
            gray_s1_q  <= 1'b0;
            idx_s1_q   <= '0;
            level_s1_q <= '0;
            de_s2_q    <= 1'b0;
            hs_s2_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            fd_s2_q    <= 1'b0;
            r_s2_q     <= '0;
            g_s2_q     <= '0;
            b_s2_q     <= '0;
        end else begin
            de_prev_q  <= I_de;
            vs_prev_q  <= I_vs;
            armed_q    <= 1'b1;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            mode_q     <= mode_d;
            de_s1_q    <= I_de;
            hs_s1_q    <= I_hs;
            vs_s1_q    <= I_vs;
            en_s1_q    <= I_en;
            rise_s1_q  <= vs_rise;
            gray_s1_q  <= gray_d;
            idx_s1_q   <= idx_d;
            level_s1_q <= level_d;
            de_s2_q    <= de_s1_q;
            hs_s2_q    <= hs_s1_q;
            vs_s2_q    <= vs_s1_q;
            fd_s2_q    <= rise_s1_q;
            r_s2_q     <= r_d;
            g_s2_q     <= g_d;
            b_s2_q     <= b_d;
        end
    end

    assign O_de         = de_s2_q;
    assign O_hs         = hs_s2_q;
    assign O_vs         = vs_s2_q;
    assign O_r          = r_s2_q;
    assign O_g          = g_s2_q;
    assign O_b          = b_s2_q;
    assign O_frame_done = fd_s2_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: pixel/line-count reference model compared every cycle,
// plus literal pixel checks on captured output frames.
module tb_video_pattern_gen;

    localparam int HRes = 1280;

    logic       clk = 1'b0;
    logic       rst, en, de, hs, vs;
    logic [1:0] mode;
    logic       o_de, o_hs, o_vs, o_fd;
    logic [7:0] o_r, o_g, o_b;

    always #5 clk = ~clk;

    video_pattern_gen dut (
        .I_pxl_clk   (clk),
        .I_rst       (rst),
        .I_en        (en),
        .I_mode      (mode),
        .I_de        (de),
        .I_hs        (hs),
        .I_vs        (vs),
        .O_de        (o_de),
        .O_hs        (o_hs),
        .O_vs        (o_vs),
        .O_r         (o_r),
        .O_g         (o_g),
        .O_b         (o_b),
        .O_frame_done(o_fd)
    );

    int total = 0;
    int bad = 0;
    int nprint = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (nprint < 40) $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
            nprint++;
        end
    endtask

    function automatic logic [23:0] pal(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pattern(input int m, input int x, input int y, input int f);
        int b;
        logic [7:0] g;
        case (m)
            0: begin
                b = x / (HRes / 8);
                return pal(b > 7 ? 7 : b);
            end
            1: return pal(f);
            2: return (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                g = 8'((x >> 2) % 256);
                return {g, g, g};
            end
        endcase
    endfunction

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fd;
        logic [23:0] rgb;
    } ent_t;

    // Reference model: pixel index within the line, line index within the frame
    int   m_px = 0, m_line = 0, m_mode = 0, m_frame = 0;
    bit   m_prev_de = 0, m_prev_vs = 0, m_vs_known = 0;
    ent_t s1 = '0, s2 = '0;

    // Output-side capture of what the DUT actually drew
    logic [23:0] cap [0:47][0:1279];
    int   ocnt [0:47];
    int   o_px = 0, o_line = 0;
    bit   prev_ode = 0, prev_ovs = 0, prev_ohs = 0;
    int   fd_cnt = 0, hs_rise_cnt = 0;
    int   t_in = 0, t_out = 0;
    bit   t_in_valid = 0, t_out_valid = 0;

    always @(posedge clk) begin
        ent_t e;
        bit rise, fall, rst_now;
        cyc++;
        rst_now = rst;
        if (rst) begin
            m_px = 0; m_line = 0; m_mode = 0; m_frame = 0;
            m_prev_de = 0; m_prev_vs = 0; m_vs_known = 0;
            s1 = '0; s2 = '0;
        end else begin
            rise = m_vs_known && vs && !m_prev_vs;
            fall = m_prev_de && !de;
            e.de = de; e.hs = hs; e.vs = vs; e.fd = rise;
            e.rgb = (de && en) ? pattern(m_mode, m_px, m_line, m_frame) : 24'h0;
            s2 = s1;
            s1 = e;
            if (fall) m_px = 0;
            else if (de && m_px < 4095) m_px++;
            if (rise) m_line = 0;
            else if (fall && m_line < 4095) m_line++;
            if (rise) begin
                m_mode = mode;
                m_frame = (m_frame + 1) % 8;
            end
            m_prev_de = de; m_prev_vs = vs; m_vs_known = 1;
        end
        #1;
        check("pipe", {4'h0, o_de, o_hs, o_vs, o_fd, o_r, o_g, o_b}, {4'h0, s2});
        if (rst_now) check("rst_zero", {4'h0, o_de, o_hs, o_vs, o_fd, o_r, o_g, o_b}, 32'h0);

        if (o_vs && !prev_ovs) begin
            o_line = 0;
            o_px = 0;
        end
        if (o_de) begin
            if (o_line < 48 && o_px < 1280) cap[o_line][o_px] = {o_r, o_g, o_b};
            if (!prev_ode && !t_out_valid) begin
                t_out = cyc;
                t_out_valid = 1;
            end
            o_px++;
        end else if (prev_ode) begin
            if (o_line < 48) ocnt[o_line] = o_px;
            o_line++;
            o_px = 0;
        end
        if (o_hs && !prev_ohs) hs_rise_cnt++;
        if (o_fd) fd_cnt++;
        prev_ode = o_de; prev_ovs = o_vs; prev_ohs = o_hs;
    end

    // Stimulus
    int sw_line = -1, sw_mode = 0, off_line = -1, rst_line = -1, rst_px = -1, rst_cnt = 0;
    bit en_def = 1;

    task automatic drive(input bit d, input bit h, input bit v);
        @(negedge clk);
        if (rst_cnt > 0) begin
            rst = 1'b1;
            rst_cnt--;
        end else begin
            rst = 1'b0;
        end
        if (d && !de && !t_in_valid) begin
            t_in = cyc;
            t_in_valid = 1;
        end
        de = d; hs = h; vs = v;
    endtask

    task automatic do_reset(input int n);
        rst_cnt = n;
        repeat (n) drive(0, 0, 0);
        repeat (3) drive(0, 0, 0);
    endtask

    task automatic line(input int hact, input int l);
        if (l == sw_line) mode = 2'(sw_mode);
        en = (l == off_line) ? 1'b0 : en_def;
        repeat (4) drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);
        for (int p = 0; p < hact; p++) begin
            if (l == rst_line && p == rst_px) rst_cnt = 3;
            drive(1, 0, 0);
        end
        repeat (4) drive(0, 0, 0);
    endtask

    task automatic frame(input int nl, input int hact);
        repeat (6) drive(0, 0, 1);
        repeat (2) drive(0, 0, 0);
        for (int l = 0; l < nl; l++) line(hact, l);
    endtask

    logic [23:0] m1_exp [0:8];

    initial begin
        int fd0, hs0, nl, hact;
        rst = 1'b1; en = 1'b1; de = 0; hs = 0; vs = 0; mode = 2'd0;
        m1_exp = '{24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000,
                   24'h0000FF, 24'h000000, 24'hFFFFFF, 24'hFFFF00};

        // Colour bars, first line of the frame
        do_reset(3);
        t_in_valid = 0; t_out_valid = 0;
        frame(2, 1280);
        check("bar_px0", cap[0][0], 24'hFFFFFF);
        check("bar_px159", cap[0][159], 24'hFFFFFF);
        check("bar_px160", cap[0][160], 24'hFFFF00);
        check("bar_px319", cap[0][319], 24'hFFFF00);
        check("bar_px1120", cap[0][1120], 24'h000000);
        check("bar_px1279", cap[0][1279], 24'h000000);
        check("de_latency", 32'(t_out - t_in), 32'd2);

        // Per-frame solid colours with frame counter wrap
        mode = 2'd1;
        do_reset(3);
        for (int f = 0; f < 9; f++) begin
            fd0 = fd_cnt;
            frame(2, 16);
            check("solid_colour", cap[0][0], m1_exp[f]);
            check("solid_colour_mid", cap[1][8], m1_exp[f]);
            check("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
        end

        // Grid
        mode = 2'd2;
        frame(42, 80);
        check("grid_0_5", cap[5][0], 24'hFFFFFF);
        check("grid_33_33", cap[33][33], 24'h000000);
        check("grid_64_40", cap[40][64], 24'hFFFFFF);
        check("grid_5_32", cap[32][5], 24'hFFFFFF);

        // Gray gradient with wrap
        mode = 2'd3;
        frame(1, 1100);
        check("grad_x4", cap[0][4], 24'h010101);
        check("grad_x1023", cap[0][1023], 24'hFFFFFF);
        check("grad_x1024", cap[0][1024], 24'h000000);

        // Mid-frame mode change is deferred; an I_en=0 line is black but timing continues
        mode = 2'd0;
        frame(1, 200);
        sw_line = 1; sw_mode = 2; off_line = 2;
        hs0 = hs_rise_cnt;
        frame(4, 200);
        check("defer_mode", cap[1][40], 24'hFFFFFF);
        check("en_off_px40", cap[2][40], 24'h000000);
        check("en_off_px0", cap[2][0], 24'h000000);
        check("en_off_de_cnt", 32'(ocnt[2]), 32'd200);
        check("hs_toggles", 32'(hs_rise_cnt - hs0), 32'd4);
        sw_line = -1; off_line = -1;
        frame(2, 200);
        check("mode2_applied", cap[1][40], 24'h000000);
        check("mode2_col0", cap[1][0], 24'hFFFFFF);

        // Reset pulsed mid-line, then a clean bar frame
        mode = 2'd0;
        rst_line = 0; rst_px = 100;
        frame(2, 200);
        rst_line = -1;
        frame(1, 1280);
        check("post_rst_px0", cap[0][0], 24'hFFFFFF);
        check("post_rst_px159", cap[0][159], 24'hFFFFFF);
        check("post_rst_px160", cap[0][160], 24'hFFFF00);
        check("post_rst_px1279", cap[0][1279], 24'h000000);

        // Randomised frames against the model
        for (int f = 0; f < 12; f++) begin
            nl = $urandom_range(1, 5);
            hact = $urandom_range(20, 400);
            mode = 2'($urandom % 4);
            en_def = ($urandom % 4) != 0;
            sw_line = ($urandom % 2 == 0) ? int'($urandom % nl) : -1;
            sw_mode = $urandom % 4;
            off_line = ($urandom % 3 == 0) ? int'($urandom % nl) : -1;
            rst_line = ($urandom % 5 == 0) ? int'($urandom % nl) : -1;
            rst_px = $urandom % hact;
            frame(nl, hact);
        end
        rst_line = -1;
        repeat (5) drive(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 The module SHALL have parameter H_RES, default 1280, meaning active pixels per line.
REQ-002 The module SHALL have parameter V_RES, default 720, meaning active lines per frame.
REQ-003 The module SHALL have parameter GRID_LOG2, default 5, meaning grid pitch = 2^GRID_LOG2 pixels.
REQ-004 The module SHALL have parameter GRAD_SHIFT, default 2, meaning the right-shift applied to x for the gradient pattern.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port I_pxl_clk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-007 Port I_rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port I_en, input, 1 bit: pattern enable; when 0, RGB is black and syncs still pass.
REQ-009 Port I_mode, input, 2 bits: 0 = colour bars, 1 = per-frame solid cycle, 2 = grid, 3 = gray gradient.
REQ-010 Ports I_de, I_hs and I_vs, inputs, 1 bit each: timing from the upstream timing generator; all active-high.
REQ-011 Ports O_de, O_hs and O_vs, outputs, 1 bit each: inputs delayed by exactly 2 clocks, to feed the DVI transmitter.
REQ-012 Ports O_r, O_g and O_b, outputs, 8 bits each: pixel colour aligned with O_de.
REQ-013 Port O_frame_done, output, 1 bit: one-clock pulse on the cycle O_vs rises.

Function
REQ-014 The module SHALL keep a 12-bit x counter that increments on each cycle with I_de=1 and clears to 0 on the cycle after I_de falls.
- x SHALL saturate at 4095.
REQ-015 The module SHALL keep a 12-bit y counter that increments on each I_de falling edge and clears to 0 on each I_vs rising edge.
- y SHALL saturate at 4095.
- When a vs rise and a de fall occur in the same cycle, the clear SHALL win.
REQ-016 On each I_vs rising edge the module SHALL:
- latch I_mode into mode_q;
- increment a 3-bit frame counter, wrapping 7->0.
I_mode changes mid-frame SHALL have no effect until the next I_vs rise.
REQ-017 The pipeline SHALL have two stages, for a fixed latency of 2 clocks from I_de/I_hs/I_vs to O_*:
- stage 1 registers x, y, de, hs, vs and the colour select;
- stage 2 registers RGB and the delayed syncs.
REQ-018 The colour table, index 0..7, SHALL be white, yellow, cyan, green, magenta, red, blue, black. Each component is 255 or 0 as the name implies.
REQ-019 Mode 0 SHALL select bar index = x / (H_RES/8), saturated at 7.
REQ-020 Mode 1 SHALL select table index = frame counter, so the whole frame is one colour.
REQ-021 Mode 2 SHALL output white when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, and black otherwise.
REQ-022 Mode 3 SHALL output R=G=B=(x >> GRAD_SHIFT)[7:0], truncated so it wraps.
REQ-023 O_r, O_g and O_b SHALL be 0 whenever the delayed de is 0 or I_en (sampled in stage 1) is 0.
REQ-024 Syncs SHALL pass unmodified regardless of I_en and mode.
REQ-025 O_frame_done SHALL be high for exactly one clock per O_vs rising edge and never while I_rst=1.

Reset
REQ-026 While I_rst=1, all of the following SHALL be 0 on the next clock edge:
- O_de, O_hs, O_vs, O_r, O_g, O_b, O_frame_done;
- x, y, frame counter, mode_q, and all pipeline and edge-detect registers.
REQ-027 After I_rst deasserts mid-frame:
- x SHALL count correctly from the next I_de rise;
- y SHALL count from 0 until the next I_vs rise;
- no frame_done pulse SHALL occur until a real I_vs rising edge is seen.
REQ-028 After reset, the first pattern SHALL be mode 0 (mode_q=0) until the first I_vs rise.

Verification
REQ-029 Reset, then a 1280x720 timing stream with I_mode=0 and I_en=1 -> on line 0 of the O_de window:
- pixels 0..159 are 255/255/255;
- pixels 160..319 are R=255, G=255, B=0;
- pixels 1120..1279 are 0/0/0;
- O_de rises exactly 2 clocks after I_de.
REQ-030 I_mode=1 over 9 frames -> frame colours are yellow, cyan, green, magenta, red, blue, black, white, yellow (counter wraps 7->0), with one O_frame_done per frame.
REQ-031 I_mode=2 -> pixel (0,5) is white, (33,33) is black, (64,40) is white and (5,32) is white.
REQ-032 I_mode=3 -> pixel x=4 gives RGB=1/1/1, x=1023 gives 255, and x=1024 gives 0 (wrap).
REQ-033 I_mode switches 0->2 mid-frame, then I_en=0 for one line -> the pattern changes only after the next I_vs rise; during the I_en=0 line RGB=0 while O_hs/O_de still toggle.
REQ-034 I_rst pulsed for 3 clocks mid-line -> all outputs are 0 during reset; the next full frame is correct mode-0 bars with x starting at 0.
